// File: rtl/elevator_car_ctrl_if.sv
// Bus between the elevator car controller and its surroundings.
// Signals:
//   enable     : 1 = car runs, 0 = car frozen (calls still latch)
//   floor_call : one-cycle call pulses, bit i requests floor i
//   level      : current floor of the car (0..3)
//   motor_up   : motor drive upwards
//   motor_down : motor drive downwards
//   door_open  : door is open
//   pending    : latched calls not yet served
//   sevenseg   : active-low {dp,g,f,e,d,c,b,a} showing level+1
// Modports: master drives enable/floor_call, slave is the controller.
interface elevator_car_ctrl_if;
    logic       enable;
    logic [3:0] floor_call;
    logic [1:0] level;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;
    logic [7:0] sevenseg;

    modport master (
        output enable, floor_call,
        input  level, motor_up, motor_down, door_open, pending, sevenseg
    );

    modport slave (
        input  enable, floor_call,
        output level, motor_up, motor_down, door_open, pending, sevenseg
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Four-floor elevator car controller.
// The car idles until calls are pending, travels one floor per TRAVEL_CYCLES
// clocks in its current direction, stops at the first floor with a latched
// call and holds the door open for DOOR_CYCLES clocks.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, priority over everything
//   bus   : elevator_car_ctrl_if.slave (enable, floor_call in; level,
//           motor_up, motor_down, door_open, pending, sevenseg out)
// All outputs are registered.
module elevator_car_ctrl #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                clk,
    input  logic                reset,
    elevator_car_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TRAVEL_CYCLES);
    localparam int DW = $clog2(DOOR_CYCLES);

    // Counters hold "cycles left after this one", so zero marks the last cycle.
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    // A call at the stopped floor counts its own cycle as the first of a
    // fresh DOOR_CYCLES-long opening, hence one less than a normal load.
    localparam logic [DW-1:0] DOOR_RELOAD = DW'(DOOR_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [1:0]    level_r, level_nxt_s;
    logic          dir_r, dir_nxt_s;          // 1 = up, 0 = down
    logic [3:0]    pending_r, pending_nxt_s;
    logic [TW-1:0] travel_cnt_r, travel_nxt_s;
    logic [DW-1:0] door_cnt_r, door_nxt_s;
    logic          motor_up_r, motor_down_r, door_open_r;
    logic [7:0]    sevenseg_r;

    logic [3:0]    here_s;
    logic [3:0]    pend_set_s;
    logic          call_here_s;
    logic          any_above_s, any_below_s;
    logic [1:0]    arrive_lvl_s;
    logic [3:0]    arrive_here_s;

    // Floors strictly above (up=1) or strictly below (up=0) the given floor.
    function automatic logic [3:0] ahead_mask(input logic [1:0] lvl, input logic up);
        logic [3:0] m;
        if (up) begin
            m = 4'b1110 << lvl;
        end else begin
            m = ~(4'b1111 << lvl);
        end
        return m;
    endfunction

    // Active-low digit "level+1", decimal point always dark.
    function automatic logic [7:0] seg_encode(input logic [1:0] lvl);
        logic [7:0] s;
        case (lvl)
            2'd0:    s = 8'hF9;
            2'd1:    s = 8'hA4;
            2'd2:    s = 8'hB0;
            2'd3:    s = 8'h99;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Next-state, counter, direction and call-latch logic.
    always_comb begin
        state_nxt_s   = state_r;
        level_nxt_s   = level_r;
        dir_nxt_s     = dir_r;
        travel_nxt_s  = travel_cnt_r;
        door_nxt_s    = door_cnt_r;
        here_s        = 4'b0001 << level_r;
        call_here_s   = |(bus.floor_call & here_s);
        any_above_s   = |(pending_r & ahead_mask(level_r, 1'b1));
        any_below_s   = |(pending_r & ahead_mask(level_r, 1'b0));
        arrive_lvl_s  = level_r;
        arrive_here_s = here_s;

        // A stopped car answers a call to its own floor with the door instead
        // of latching it; calls latch even while the car is frozen.
        if ((state_r == IDLE) || (state_r == DOOR_OPEN)) begin
            pend_set_s = bus.floor_call & ~here_s;
        end else begin
            pend_set_s = bus.floor_call;
        end
        pending_nxt_s = pending_r | pend_set_s;

        if (bus.enable) begin
            case (state_r)
                IDLE: begin
                    if (call_here_s || (|(pending_r & here_s))) begin
                        state_nxt_s   = DOOR_OPEN;
                        door_nxt_s    = DOOR_LOAD;
                        pending_nxt_s = pending_nxt_s & ~here_s;
                    end else if (any_above_s && (dir_r || !any_below_s)) begin
                        state_nxt_s  = MOVE_UP;
                        dir_nxt_s    = 1'b1;
                        travel_nxt_s = TRAVEL_LOAD;
                    end else if (any_below_s) begin
                        state_nxt_s  = MOVE_DOWN;
                        dir_nxt_s    = 1'b0;
                        travel_nxt_s = TRAVEL_LOAD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (travel_cnt_r != {TW{1'b0}}) begin
                        travel_nxt_s = travel_cnt_r - {{(TW-1){1'b0}}, 1'b1};
                    end else if (((state_r == MOVE_UP) && (level_r == 2'd3)) ||
                                 ((state_r == MOVE_DOWN) && (level_r == 2'd0))) begin
                        // Shaft end: never drive past it.
                        state_nxt_s  = IDLE;
                        travel_nxt_s = TRAVEL_LOAD;
                    end else begin
                        if (state_r == MOVE_UP) begin
                            arrive_lvl_s = level_r + 2'd1;
                        end else begin
                            arrive_lvl_s = level_r - 2'd1;
                        end
                        arrive_here_s = 4'b0001 << arrive_lvl_s;
                        level_nxt_s   = arrive_lvl_s;
                        travel_nxt_s  = TRAVEL_LOAD;
                        // A call arriving on the arrival edge is served right away.
                        if (|((pending_r | bus.floor_call) & arrive_here_s)) begin
                            state_nxt_s   = DOOR_OPEN;
                            door_nxt_s    = DOOR_LOAD;
                            pending_nxt_s = pending_nxt_s & ~arrive_here_s;
                        end else if (|(pending_nxt_s & ahead_mask(arrive_lvl_s, dir_r))) begin
                            state_nxt_s = state_r;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (call_here_s) begin
                        door_nxt_s = DOOR_RELOAD;
                    end else if (door_cnt_r != {DW{1'b0}}) begin
                        door_nxt_s = door_cnt_r - {{(DW-1){1'b0}}, 1'b1};
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            level_r      <= 2'd0;
            dir_r        <= 1'b1;
            pending_r    <= 4'b0000;
            travel_cnt_r <= {TW{1'b0}};
            door_cnt_r   <= {DW{1'b0}};
            motor_up_r   <= 1'b0;
            motor_down_r <= 1'b0;
            door_open_r  <= 1'b0;
            sevenseg_r   <= 8'hF9;
        end else begin
            state_r      <= state_nxt_s;
            level_r      <= level_nxt_s;
            dir_r        <= dir_nxt_s;
            pending_r    <= pending_nxt_s;
            travel_cnt_r <= travel_nxt_s;
            door_cnt_r   <= door_nxt_s;
            motor_up_r   <= (state_nxt_s == MOVE_UP);
            motor_down_r <= (state_nxt_s == MOVE_DOWN);
            door_open_r  <= (state_nxt_s == DOOR_OPEN);
            sevenseg_r   <= seg_encode(level_nxt_s);
        end
    end

    assign bus.level      = level_r;
    assign bus.motor_up   = motor_up_r;
    assign bus.motor_down = motor_down_r;
    assign bus.door_open  = door_open_r;
    assign bus.pending    = pending_r;
    assign bus.sevenseg   = sevenseg_r;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl (TRAVEL_CYCLES=4, DOOR_CYCLES=3):
// a fixed vector table, hand-written corner sequences and a random run,
// all compared against constants or a floor/queue-level reference model.
module tb_elevator_car_ctrl;
    localparam int TC = 4;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic reset;
    elevator_car_ctrl_if bus_if();

    elevator_car_ctrl #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: what the car is doing, which floor it is at, how many
    // cycles of the current move/door opening remain, and the call set.
    typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mmode_t;
    mmode_t     m_mode;
    int         m_floor;
    bit         m_up;
    bit [3:0]   m_pend;
    int         m_left;
    int         m_door;
    logic [7:0] seg_tab [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

    task automatic model_step(input bit rst, input bit en, input logic [3:0] call);
        bit [3:0] np;
        bit stopped, any_up, any_dn, ahead;
        if (rst) begin
            m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_pend = 4'b0000;
            m_left = 0; m_door = 0;
        end else begin
            stopped = (m_mode == M_IDLE) || (m_mode == M_DOOR);
            np = m_pend;
            for (int i = 0; i < 4; i++)
                if (call[i] && !(stopped && i == m_floor)) np[i] = 1'b1;
            if (en) begin
                case (m_mode)
                    M_IDLE: begin
                        any_up = 1'b0; any_dn = 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            if (m_pend[i] && i > m_floor) any_up = 1'b1;
                            if (m_pend[i] && i < m_floor) any_dn = 1'b1;
                        end
                        if (call[m_floor] || m_pend[m_floor]) begin
                            m_mode = M_DOOR; m_door = DC; np[m_floor] = 1'b0;
                        end else if (any_up && (m_up || !any_dn)) begin
                            m_mode = M_UP; m_up = 1'b1; m_left = TC;
                        end else if (any_dn) begin
                            m_mode = M_DOWN; m_up = 1'b0; m_left = TC;
                        end
                    end
                    M_UP, M_DOWN: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
                            m_left = TC;
                            if (m_pend[m_floor] || call[m_floor]) begin
                                m_mode = M_DOOR; m_door = DC; np[m_floor] = 1'b0;
                            end else begin
                                ahead = 1'b0;
                                for (int i = 0; i < 4; i++)
                                    if (np[i] && ((m_up && i > m_floor) || (!m_up && i < m_floor)))
                                        ahead = 1'b1;
                                if (!ahead) m_mode = M_IDLE;
                            end
                        end
                    end
                    M_DOOR: begin
                        if (call[m_floor]) begin
                            m_door = DC - 1;
                        end else begin
                            m_door--;
                            if (m_door == 0) m_mode = M_IDLE;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            m_pend = np;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"},    {6'b0, bus_if.level},      8'(m_floor));
        check({tag, ".motor_up"}, {7'b0, bus_if.motor_up},   8'(m_mode == M_UP));
        check({tag, ".motor_dn"}, {7'b0, bus_if.motor_down}, 8'(m_mode == M_DOWN));
        check({tag, ".door"},     {7'b0, bus_if.door_open},  8'(m_mode == M_DOOR));
        check({tag, ".pending"},  {4'b0, bus_if.pending},    {4'b0, m_pend});
        check({tag, ".sevenseg"}, bus_if.sevenseg,           seg_tab[m_floor]);
        check({tag, ".motor_excl"}, {7'b0, bus_if.motor_up & bus_if.motor_down}, 8'h00);
    endtask

    // Drive inputs, take one edge, advance the model, settle.
    task automatic step(input bit rst, input bit en, input logic [3:0] call);
        reset = rst;
        bus_if.enable = en;
        bus_if.floor_call = call;
        @(posedge clk);
        model_step(rst, en, call);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] call;
        logic [1:0] lvl;
        bit         mu;
        bit         md;
        bit         door;
        logic [3:0] pend;
        logic [7:0] seg;
    } vec_t;
    vec_t vecs [14];

    initial begin
        int md_cnt, door_cnt, first_l1;
        bit en;
        logic [3:0] call;

        reset = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.floor_call = 4'b0000;

        // Reset, then a call to floor 2: 8 motor_up cycles, door 3 cycles.
        vecs[0] = '{1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 8'hF9};
        vecs[1] = '{1'b0, 1'b1, 4'h4, 2'd0, 1'b0, 1'b0, 1'b0, 4'h4, 8'hF9};
        for (int i = 2; i <= 5; i++)
            vecs[i] = '{1'b0, 1'b1, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h4, 8'hF9};
        for (int i = 6; i <= 9; i++)
            vecs[i] = '{1'b0, 1'b1, 4'h0, 2'd1, 1'b1, 1'b0, 1'b0, 4'h4, 8'hA4};
        for (int i = 10; i <= 12; i++)
            vecs[i] = '{1'b0, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 1'b1, 4'h0, 8'hB0};
        vecs[13] = '{1'b0, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0, 8'hB0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].call);
            check($sformatf("vec%0d.level", i),    {6'b0, bus_if.level},      {6'b0, vecs[i].lvl});
            check($sformatf("vec%0d.motor_up", i), {7'b0, bus_if.motor_up},   {7'b0, vecs[i].mu});
            check($sformatf("vec%0d.motor_dn", i), {7'b0, bus_if.motor_down}, {7'b0, vecs[i].md});
            check($sformatf("vec%0d.door", i),     {7'b0, bus_if.door_open},  {7'b0, vecs[i].door});
            check($sformatf("vec%0d.pending", i),  {4'b0, bus_if.pending},    {4'b0, vecs[i].pend});
            check($sformatf("vec%0d.sevenseg", i), bus_if.sevenseg,           vecs[i].seg);
        end

        // At floor 2 heading up, calls to 3 and 0: up first, then 12 cycles down.
        md_cnt = 0;
        step(1'b0, 1'b1, 4'b1001);
        check_model("dual");
        for (int s = 0; s < 39; s++) begin
            step(1'b0, 1'b1, 4'b0000);
            check_model("dual");
            if (bus_if.motor_down) md_cnt++;
        end
        check("dual.down_cycles", 8'(md_cnt), 8'd12);
        check("dual.end_level", {6'b0, bus_if.level}, 8'd0);
        check("dual.end_pending", {4'b0, bus_if.pending}, 8'h00);

        // Freeze mid-move, call while frozen, then re-call floor 1 during its door.
        first_l1 = -1;
        door_cnt = 0;
        for (int s = 0; s < 32; s++) begin
            en = !(s >= 4 && s <= 8);
            call = (s == 0) ? 4'b0010 : (s == 6) ? 4'b1000 : (s == 12) ? 4'b0010 : 4'b0000;
            step(1'b0, en, call);
            check_model("freeze");
            if (first_l1 < 0 && bus_if.level == 2'd1) first_l1 = s;
            if (s < 15 && bus_if.door_open) door_cnt++;
            if (s == 6) check("freeze.pend_while_off", {4'b0, bus_if.pending}, 8'h0A);
            if (s == 12) check("door.pend1_not_set", {7'b0, bus_if.pending[1]}, 8'h00);
        end
        check("freeze.arrival_step", 8'(first_l1), 8'd10);
        check("door.open_cycles", 8'(door_cnt), 8'd4);
        check("freeze.end_level", {6'b0, bus_if.level}, 8'd3);

        // Reset on the third motor_up cycle out of floor 0.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0010);
        for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 4'b0000);
        check("abort.moving", {7'b0, bus_if.motor_up}, 8'h01);
        step(1'b1, 1'b1, 4'b0100);
        check_model("abort");
        check("abort.level", {6'b0, bus_if.level}, 8'd0);
        check("abort.motor_up", {7'b0, bus_if.motor_up}, 8'h00);
        check("abort.pending", {4'b0, bus_if.pending}, 8'h00);
        check("abort.sevenseg", bus_if.sevenseg, 8'hF9);

        // Random traffic against the model.
        for (int s = 0; s < 800; s++) begin
            en = ($urandom_range(0, 9) != 0);
            call = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            step(($urandom_range(0, 199) == 0), en, call);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, meaning: clock cycles of motor drive per one-floor move (legal range >=2).
REQ-002 Parameter DOOR_CYCLES, default 6, meaning: clock cycles the door stays open per stop (legal range >=2).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = car runs; 0 = state, timers and outputs frozen.
REQ-006 floor_call  input  4  one-cycle call pulses; bit i requests floor i (0..3); several bits may be high at once.
REQ-007 Level  output  2  current floor of the car, registered.
REQ-008 motor_up / motor_down  output  1 each  motor drive; never both high.
REQ-009 door_open  output  1  high while in DOOR_OPEN.
REQ-010 pending  output  4  latched, not-yet-served calls.
REQ-011 sevenseg  output  8  active-low {dp,g,f,e,d,c,b,a}, shows Level+1 as digit 1..4.

Function
REQ-012 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; a direction register dir (up/down) holds the last travel direction.
REQ-013 floor_call[i]=1 SHALL set pending[i] on the next edge, regardless of enable, except when the car is at floor i in IDLE or DOOR_OPEN (then not latched; see REQ-017/018).
REQ-014 IDLE: with pending empty SHALL stay IDLE, motors off, door closed.
REQ-015 IDLE with pending calls: if calls exist in dir and in opposite direction, continue dir; if only one side has calls, go that side; transition on the next edge, set dir accordingly.
REQ-016 MOVE_UP/MOVE_DOWN: motor_up/motor_down high for exactly TRAVEL_CYCLES cycles per floor; on the edge ending the last cycle Level increments/decrements by 1 and the travel counter reloads.
REQ-017 On arrival, if pending[new Level]=1: clear that bit on the same edge and enter DOOR_OPEN; else continue moving one more floor (calls further in direction guaranteed to exist by REQ-015).
REQ-018 A call to the current floor while in IDLE SHALL enter DOOR_OPEN on the next edge without setting pending.
REQ-019 DOOR_OPEN: door_open high for DOOR_CYCLES cycles, then IDLE; a call to the current floor during DOOR_OPEN restarts the door counter to DOOR_CYCLES.
REQ-020 Level SHALL never exceed 3 nor go below 0; MOVE_UP never entered at floor 3, MOVE_DOWN never at floor 0.
REQ-021 enable=0: state, counters, Level, dir and motor/door outputs hold; only pending may set per REQ-013; resumption continues the remaining count exactly.
REQ-022 sevenseg encodings: Level 0 -> 0xF9, 1 -> 0xA4, 2 -> 0xB0, 3 -> 0x99; dp (bit 7) always 1.

Reset
REQ-023 reset=1 SHALL, on the next edge, force state IDLE, Level=0, dir=up, pending=0, motors off, door_open=0, sevenseg=0xF9, counters cleared; reset has priority over enable and floor_call.
REQ-024 Reset asserted mid-move or mid-door SHALL abort the operation with no partial Level change.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-025 After reset, pulse floor_call=4'b0100 -> pending=0100 next cycle; motor_up 8 cycles; Level 1 after 4, Level 2 after 8 (sevenseg 0xB0); pending=0; door_open exactly 3 cycles; IDLE.
REQ-026 At Level 2, dir=up, pulse floor_call=4'b1001 -> moves up to 3 first (door 3 cycles), then down to 0 (12 motor_down cycles), pending=0 at end.
REQ-027 Mid-move, drop enable for 5 cycles -> motor output and travel count frozen, arrival delayed exactly 5 cycles; call pulsed while disabled appears in pending.
REQ-028 During DOOR_OPEN at floor 1, pulse floor_call[1] on the 2nd door cycle -> door_open lasts 1+3 cycles total; pending[1] stays 0.
REQ-029 Assert reset on 3rd motor_up cycle from floor 0 -> next edge Level=0, motors off, pending=0, sevenseg=0xF9.
REQ-030 Whole run: assert motor_up&motor_down never, and Level never changes outside a move arrival.
